multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//   Moore FSM that sequences a shared-memory multicycle RV32I datapath:
//   PC, IR, OldPC, A/B, ALUOut, Data registers, one ALU and one memory port.
//   Decodes op/funct3/funct7b5 and drives every mux select and write strobe.
//   Stretches memory states with a ready handshake for slow memories.
//   Replaces the combinational single-cycle controller when the datapath is
//   built in its multicycle form.
// PARAMETERS
//   CNT_W       32  width of performance counters (MC_PERF_CNT_EN only)
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   op           in   7   instr[6:0] from IR
//   funct3       in   3   instr[14:12]
//   funct7b5     in   1   instr[30]
//   zero         in   1   ALU zero flag
//   mem_ready    in   1   memory completes access this cycle
//   pc_write     out  1   load PC (unconditional or taken branch)
//   adr_src      out  1   0: address=PC, 1: address=ALUOut
//   ir_write     out  1   load IR and OldPC
//   mem_write    out  1   memory write strobe
//   reg_write    out  1   register-file write strobe
//   alu_src_a    out  2   00 PC, 01 OldPC, 10 rs1 (A)
//   alu_src_b    out  2   00 rs2 (B), 01 ImmExt, 10 const 4
//   result_src   out  2   00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   alu_control  out  3   000 add, 001 sub, 010 and, 011 or, 101 slt
//   imm_src      out  3   000 I, 001 S, 010 B, 011 J, 100 U
//   illegal_instr out 1   one-cycle pulse on unsupported opcode
//   busy_fetch   out  1   state==FETCH
// BEHAVIOUR
//   States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
//     ALUWB, EXECI, JAL, BRANCH, LUI. Reset -> FETCH; all strobes 0 during reset.
//   FETCH: adr_src=0, srcA=PC, srcB=4, add, result_src=10. Stays while
//     !mem_ready. On mem_ready: ir_write=1, pc_write=1, next DECODE.
//   DECODE: srcA=OldPC, srcB=ImmExt, add (branch/jal target into ALUOut).
//     lw/sw->MEMADR; 0110011->EXECR; 0010011->EXECI; 1101111->JAL;
//     1100011->BRANCH; 0110111->LUI; else illegal_instr=1, ->FETCH.
//   MEMADR: srcA=A, srcB=ImmExt, add. lw->MEMREAD, sw->MEMWRITE.
//   MEMREAD: adr_src=1; hold until mem_ready; then ->MEMWB.
//   MEMWB: result_src=01, reg_write=1, ->FETCH.
//   MEMWRITE: adr_src=1, mem_write=1 held every cycle until mem_ready; ->FETCH.
//   EXECR/EXECI: srcA=A, srcB=B / ImmExt, ALU op from funct3; ->ALUWB.
//   ALUWB: result_src=00, reg_write=1, ->FETCH.
//   JAL: srcA=OldPC, srcB=4, add, result_src=00, pc_write=1 (PC<=ALUOut
//     target); ->ALUWB (rd<=PC+4).
//   BRANCH: srcA=A, srcB=B, sub, result_src=00; pc_write=zero for funct3 000
//     (beq), ~zero for 001 (bne); other funct3 -> illegal_instr, no write.
//     ->FETCH.
//   LUI: result_src=11, imm_src=100, reg_write=1, ->FETCH.
//   ALU decode: 000 add (sub if EXECR & funct7b5), 010 slt, 110 or, 111 and;
//     other funct3 -> add plus illegal_instr pulse in EXEC state.
//   imm_src by op: I for lw/I-alu, S sw, B branch, J jal, U lui; 000 default.
//   Latency (mem_ready=1): lw 5, sw/R/I/jal 4, beq/bne/lui 3, illegal 2.
//   Strobes never overlap: at most one of reg_write/mem_write/ir_write high,
//     except FETCH ir_write+pc_write.
//   Reset mid-instruction: FSM returns to FETCH asynchronously, all strobes
//     drop same cycle; no partial writes after reset release.
//   mem_ready ignored in non-memory states.
// CONFIGURATION
//   MC_PERF_CNT_EN defined: adds outputs cycle_cnt[CNT_W-1:0] (+1 every clk)
//     and instret_cnt[CNT_W-1:0] (+1 on each transition into FETCH from a
//     completing state, not illegal); both reset to 0, wrap at 2^CNT_W.
//   Undefined: counters and ports absent; FSM behaviour identical.
// TESTING
//   reset high mid-MEMREAD -> state FETCH, reg_write=mem_write=0 immediately.
//   add x3,x1,x2 (funct7b5=0), mem_ready=1 -> 4 cycles, reg_write in
//     cycle 4, alu_control=000.
//   lw with mem_ready low 3 cycles in MEMREAD -> 8 total, one reg_write pulse.
//   sw, mem_ready=1 -> mem_write high exactly 1 cycle, adr_src=1.
//   beq zero=1 -> pc_write in BRANCH; bne zero=1 -> no pc_write; 3 cycles.
//   op=7'b1111111 -> illegal_instr 1 cycle in DECODE, back to FETCH.
//   MC_PERF_CNT_EN: 3 adds then lui -> instret_cnt=4, cycle_cnt=15.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: Moore FSM sequencing the shared-memory datapath.
// Define MC_PERF_CNT_EN to add cycle_cnt/instret_cnt performance counter outputs.
module multicycle_controller
`ifdef MC_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal_instr,
  output logic       busy_fetch
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [3:0] state_q, state_d;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c, illegal_c;
  logic [2:0] exec_alu_ctl;
  logic       exec_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // funct7b5 selects sub only for register-register ops; addi ignores it
  always_comb begin
    exec_illegal = 1'b0;
    case (funct3)
      3'b000:  exec_alu_ctl = (state_q == S_EXECR && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  exec_alu_ctl = 3'b101;
      3'b110:  exec_alu_ctl = 3'b011;
      3'b111:  exec_alu_ctl = 3'b010;
      default: begin
        exec_alu_ctl = 3'b000;
        exec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: imm_src = 3'b000;
      OP_SW:       imm_src = 3'b001;
      OP_BR:       imm_src = 3'b010;
      OP_JAL:      imm_src = 3'b011;
      OP_LUI:      imm_src = 3'b100;
      default:     imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 3'b000;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BRANCH;
          OP_LUI:       state_d = S_LUI;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = exec_alu_ctl;
        illegal_c   = exec_illegal;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      // PC takes the target left in ALUOut by DECODE while the ALU forms the link
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        case (funct3)
          3'b000:  pc_write_c = zero;
          3'b001:  pc_write_c = ~zero;
          default: illegal_c  = 1'b1;
        endcase
        state_d = S_FETCH;
      end
      S_LUI: begin
        result_src  = 2'b11;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is high so nothing fires from FETCH
  assign pc_write      = pc_write_c  & ~reset;
  assign ir_write      = ir_write_c  & ~reset;
  assign mem_write     = mem_write_c & ~reset;
  assign reg_write     = reg_write_c & ~reset;
  assign illegal_instr = illegal_c   & ~reset;
  assign busy_fetch    = (state_q == S_FETCH);

`ifdef MC_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             instret_inc;

  assign instret_inc = (state_q != S_FETCH) && (state_d == S_FETCH) && !illegal_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_ONE;
      if (instret_inc) instret_q <= instret_q + CNT_ONE;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle scoreboard of expected control outputs.
// Counter checks are compiled in only when MC_PERF_CNT_EN is defined.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control, imm_src;
  logic       illegal_instr, busy_fetch;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // stim: {op, funct3, funct7b5, zero, mem_ready}; exp: packed control outputs
  logic [12:0] stimQ[$];
  logic [18:0] expQ[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .imm_src(imm_src), .illegal_instr(illegal_instr),
    .busy_fetch(busy_fetch)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] vec(input logic pcw, input logic adr, input logic irw,
                                      input logic memw, input logic regw, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] rs,
                                      input logic [2:0] alu, input logic [2:0] imm,
                                      input logic ill, input logic busy);
    return {pcw, adr, irw, memw, regw, sa, sb, rs, alu, imm, ill, busy};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      OP_SW:   return 3'b001;
      OP_BR:   return 3'b010;
      OP_JAL:  return 3'b011;
      OP_LUI:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Builds the expected cycle-by-cycle output trace of one instruction
  task automatic push_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int fwait, input int mwait);
    logic [2:0] imm, ac;
    logic       r, legal, aill, taken, bill, isr;
    imm = imm_of(o);
    for (int i = 0; i < fwait; i++) begin
      stimQ.push_back({o, f3, f7, z, 1'b0});
      expQ.push_back(vec(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,3'b000,imm,1'b0,1'b1));
    end
    stimQ.push_back({o, f3, f7, z, 1'b1});
    expQ.push_back(vec(1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b10,3'b000,imm,1'b0,1'b1));
    legal = (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
            (o == OP_JAL) || (o == OP_BR) || (o == OP_LUI);
    r = 1'($urandom_range(0, 1));
    stimQ.push_back({o, f3, f7, z, r});
    expQ.push_back(vec(1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,3'b000,imm,~legal,1'b0));
    isr = (o == OP_R);
    aill = 1'b0;
    case (f3)
      3'b000:  ac = (isr && f7) ? 3'b001 : 3'b000;
      3'b010:  ac = 3'b101;
      3'b110:  ac = 3'b011;
      3'b111:  ac = 3'b010;
      default: begin ac = 3'b000; aill = 1'b1; end
    endcase
    taken = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
    bill  = (f3 != 3'b000) && (f3 != 3'b001);
    r = 1'($urandom_range(0, 1));
    if (o == OP_LW || o == OP_SW) begin
      stimQ.push_back({o, f3, f7, z, r});
      expQ.push_back(vec(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b000,imm,1'b0,1'b0));
      for (int i = 0; i <= mwait; i++) begin
        stimQ.push_back({o, f3, f7, z, (i == mwait)});
        expQ.push_back(vec(1'b0,1'b1,1'b0,(o == OP_SW),1'b0,2'b00,2'b00,2'b00,3'b000,imm,1'b0,1'b0));
      end
      if (o == OP_LW) begin
        stimQ.push_back({o, f3, f7, z, r});
        expQ.push_back(vec(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b01,3'b000,imm,1'b0,1'b0));
      end
    end else if (o == OP_R || o == OP_I || o == OP_JAL) begin
      stimQ.push_back({o, f3, f7, z, r});
      if (o == OP_JAL)
        expQ.push_back(vec(1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,3'b000,imm,1'b0,1'b0));
      else
        expQ.push_back(vec(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,(isr ? 2'b00 : 2'b01),2'b00,ac,imm,aill,1'b0));
      stimQ.push_back({o, f3, f7, z, ~r});
      expQ.push_back(vec(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,imm,1'b0,1'b0));
    end else if (o == OP_BR) begin
      stimQ.push_back({o, f3, f7, z, r});
      expQ.push_back(vec(taken,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,3'b001,imm,bill,1'b0));
    end else if (o == OP_LUI) begin
      stimQ.push_back({o, f3, f7, z, r});
      expQ.push_back(vec(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b11,3'b000,3'b100,1'b0,1'b0));
    end
  endtask

  // Called at a negedge: drives one cycle of stimulus, samples, returns at next negedge
  task automatic step(output logic [18:0] obs, output logic [18:0] exp_v);
    logic [12:0] s;
    s = stimQ.pop_front();
    exp_v = expQ.pop_front();
    {op, funct3, funct7b5, zero, mem_ready} = s;
    #1;
    obs = {pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a, alu_src_b,
           result_src, alu_control, imm_src, illegal_instr, busy_fetch};
    @(negedge clk);
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    op = OP_R;
    #1;
    checks++;
    if ({pc_write, ir_write, mem_write, reg_write, illegal_instr, busy_fetch} !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL reset_state got %b expected 000001",
               {pc_write, ir_write, mem_write, reg_write, illegal_instr, busy_fetch});
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_add();
    logic [18:0] o, e;
    int cyc, rw, rw_cyc;
    cyc = 0; rw = 0; rw_cyc = 0;
    push_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
    while (expQ.size() > 0) begin
      step(o, e);
      cyc++;
      if (o[14]) begin rw++; rw_cyc = cyc; end
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL add_trace cycle %0d got %h expected %h", cyc, o, e);
      end
    end
    checks++;
    if (rw !== 1 || rw_cyc !== 4) begin
      errors++;
      $display("[TB] FAIL add_regwrite got %0d pulses at cycle %0d expected 1 at cycle 4", rw, rw_cyc);
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (busy_fetch !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_done busy_fetch got %b expected 1", busy_fetch);
    end
    @(negedge clk);
  endtask

  task automatic test_lw_wait();
    logic [18:0] o, e;
    int cyc, rw;
    cyc = 0; rw = 0;
    push_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 3);
    while (expQ.size() > 0) begin
      step(o, e);
      cyc++;
      if (o[14]) rw++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL lw_trace cycle %0d got %h expected %h", cyc, o, e);
      end
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (rw !== 1 || busy_fetch !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lw_done regwrite pulses %0d busy %b expected 1 and 1", rw, busy_fetch);
    end
    @(negedge clk);
  endtask

  task automatic test_sw();
    logic [18:0] o, e;
    int cyc, mw;
    cyc = 0; mw = 0;
    push_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 0);
    while (expQ.size() > 0) begin
      step(o, e);
      cyc++;
      if (o[15]) begin
        mw++;
        checks++;
        if (o[17] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL sw_adr_src got %b expected 1", o[17]);
        end
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL sw_trace cycle %0d got %h expected %h", cyc, o, e);
      end
    end
    checks++;
    if (mw !== 1) begin
      errors++;
      $display("[TB] FAIL sw_memwrite got %0d cycles expected 1", mw);
    end
  endtask

  task automatic test_branch();
    logic [18:0] o, e;
    logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b100};
    logic       zs  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int         tk  [5] = '{1, 0, 0, 1, 0};
    int         il  [5] = '{0, 0, 0, 0, 1};
    int pcw, ill, cyc;
    for (int k = 0; k < 5; k++) begin
      pcw = 0; ill = 0; cyc = 0;
      push_instr(OP_BR, f3s[k], 1'b0, zs[k], 0, 0);
      while (expQ.size() > 0) begin
        step(o, e);
        cyc++;
        if (o[18] && !o[0]) pcw++;
        if (o[1]) ill++;
        checks++;
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL branch%0d_trace cycle %0d got %h expected %h", k, cyc, o, e);
        end
      end
      checks++;
      if (pcw !== tk[k] || ill !== il[k]) begin
        errors++;
        $display("[TB] FAIL branch%0d_effect got pc_write %0d illegal %0d expected %0d %0d",
                 k, pcw, ill, tk[k], il[k]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [18:0] o, e;
    int ill, cyc;
    ill = 0; cyc = 0;
    push_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 1, 0);
    while (expQ.size() > 0) begin
      step(o, e);
      cyc++;
      if (o[1]) ill++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL illegal_trace cycle %0d got %h expected %h", cyc, o, e);
      end
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ill !== 1 || busy_fetch !== 1'b1 || illegal_instr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_pulse got %0d pulses busy %b expected 1 pulse busy 1", ill, busy_fetch);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    logic [18:0] o, e;
    int cyc;
    cyc = 0;
    push_instr(OP_R,   3'b000, 1'b1, 1'b0, 0, 0);
    push_instr(OP_R,   3'b010, 1'b0, 1'b0, 0, 0);
    push_instr(OP_R,   3'b110, 1'b0, 1'b0, 0, 0);
    push_instr(OP_R,   3'b111, 1'b0, 1'b0, 0, 0);
    push_instr(OP_R,   3'b101, 1'b0, 1'b0, 0, 0);
    push_instr(OP_I,   3'b000, 1'b1, 1'b0, 0, 0);
    push_instr(OP_I,   3'b010, 1'b0, 1'b0, 0, 0);
    push_instr(OP_I,   3'b110, 1'b0, 1'b0, 0, 0);
    push_instr(OP_I,   3'b111, 1'b0, 1'b0, 0, 0);
    push_instr(OP_I,   3'b001, 1'b0, 1'b0, 0, 0);
    push_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    push_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
    while (expQ.size() > 0) begin
      step(o, e);
      cyc++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL alu_ops_trace cycle %0d got %h expected %h", cyc, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] o, e;
    push_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 5);
    for (int i = 0; i < 4; i++) begin
      step(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_pre cycle %0d got %h expected %h", i, o, e);
      end
    end
    stimQ.delete();
    expQ.delete();
    mem_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy_fetch, pc_write, ir_write, mem_write, reg_write} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_mid got %b expected 10000",
               {busy_fetch, pc_write, ir_write, mem_write, reg_write});
    end
    @(negedge clk);
    reset = 1'b0;
    push_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0);
    while (expQ.size() > 0) begin
      step(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_post got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] o, e;
    logic [2:0]  alu_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [2:0]  f3r;
    logic        f7r, zr;
    int sel, fw, mw, cyc;
    cyc = 0;
    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(0, 7));
      f3r = alu_f3[$urandom_range(0, 3)];
      f7r = 1'($urandom_range(0, 1));
      zr  = 1'($urandom_range(0, 1));
      fw  = int'($urandom_range(0, 2));
      mw  = int'($urandom_range(0, 2));
      case (sel)
        0: push_instr(OP_LW, 3'b010, 1'b0, zr, fw, mw);
        1: push_instr(OP_SW, 3'b010, 1'b0, zr, fw, mw);
        2: push_instr(OP_R, f3r, f7r, zr, fw, mw);
        3: push_instr(OP_I, f3r, f7r, zr, fw, mw);
        4: push_instr(OP_JAL, 3'b000, 1'b0, zr, fw, mw);
        5: push_instr(OP_BR, {2'b00, f7r}, 1'b0, zr, fw, mw);
        6: push_instr(OP_LUI, 3'b000, 1'b0, zr, fw, mw);
        default: push_instr(OP_BAD, 3'b000, 1'b0, zr, fw, mw);
      endcase
    end
    while (expQ.size() > 0) begin
      step(o, e);
      cyc++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL b2b_trace cycle %0d got %h expected %h", cyc, o, e);
      end
    end
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    logic [18:0] o, e;
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) push_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
    push_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
    while (expQ.size() > 0) begin
      step(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL perf_trace got %h expected %h", o, e);
      end
    end
    #1;
    checks++;
    if (instret_cnt !== 32'd4 || cycle_cnt !== 32'd15) begin
      errors++;
      $display("[TB] FAIL perf_counters got instret %0d cycle %0d expected 4 15", instret_cnt, cycle_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_branch();
    test_illegal();
    test_alu_ops();
    test_reset_mid();
    test_back_to_back();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
